frv_dmem_responder: RTL and testbench

Data-memory responder: the target end of the core's dmem request/response interface. It accepts requests from the memory stage's LSU, performs them on an internal word-addressed SRAM array, and returns in-order responses after a programmable wait-state delay. It serves as a tightly coupled data RAM in SoC builds and as a configurable-latency memory model in core testbenches.

---
 rtl/frv_dmem_pkg.sv | 15 +
 rtl/frv_dmem_rsp_fifo.sv | 49 ++++
 rtl/frv_dmem_responder.sv | 94 +++++++++
 tb/tb_frv_dmem_responder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frv_dmem_pkg.sv
// Shared types and defaults for the dmem responder slice.
package frv_dmem_pkg;

  localparam int unsigned FRV_DMEM_WAIT_W      = 4;
  localparam int unsigned FRV_DMEM_DEPTH_WORDS = 1024;
  localparam logic [31:0] FRV_DMEM_BASE_ADDR   = 32'h0002_0000;

  typedef struct packed {
    logic        error;
    logic [31:0] rdata;
  } frv_dmem_rsp_t;

  localparam int unsigned FRV_DMEM_RSP_W = $bits(frv_dmem_rsp_t);

endpackage

// File: rtl/frv_dmem_rsp_fifo.sv
// In-order response queue for the dmem responder; head entry is always visible on rdata.
module frv_dmem_rsp_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 33,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = store[rd_ptr];

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/frv_dmem_responder.sv
// Data-memory target: strobed word SRAM behind a request/response port with
// in-order responses delayed by a programmable number of head wait states.
module frv_dmem_responder
  import frv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = FRV_DMEM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = FRV_DMEM_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned RSP_DEPTH   = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [3:0]  dmem_strb,
  input  logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_addr,
  output logic        dmem_gnt,
  output logic        dmem_recv,
  input  logic        dmem_ack,
  output logic        dmem_error,
  output logic [31:0] dmem_rdata
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [FRV_DMEM_WAIT_W-1:0] WAIT_MAX = FRV_DMEM_WAIT_W'(WAIT_CYCLES);
  localparam logic [32:0] RANGE_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] RANGE_HI = RANGE_LO + 33'(4 * DEPTH_WORDS);

  logic [31:0]                mem [DEPTH_WORDS];
  logic [AW-1:0]              idx;
  logic                       in_range;
  logic                       accept;
  logic                       pop;
  logic                       rsp_full;
  logic                       rsp_empty;
  logic [CNT_W-1:0]           rsp_count;
  frv_dmem_rsp_t              rsp_in;
  frv_dmem_rsp_t              rsp_head;
  logic [FRV_DMEM_WAIT_W-1:0] wctr;

  assign idx      = dmem_addr[2 +: AW];
  assign in_range = ({1'b0, dmem_addr} >= RANGE_LO) && ({1'b0, dmem_addr} < RANGE_HI);
  assign dmem_gnt = g_resetn && dmem_req && !rsp_full;
  assign accept   = dmem_req && dmem_gnt;

  // Read data is captured at accept so later writes cannot alter queued responses.
  always_comb begin
    rsp_in       = '0;
    rsp_in.error = !in_range;
    if (in_range && !dmem_wen) rsp_in.rdata = mem[idx];
  end

  always_ff @(posedge g_clk) begin
    if (accept && dmem_wen && in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (dmem_strb[i]) mem[idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

  frv_dmem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (FRV_DMEM_RSP_W)
  ) u_rsp_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push     (accept),
    .wdata    (rsp_in),
    .pop      (pop),
    .rdata    (rsp_head),
    .full     (rsp_full),
    .empty    (rsp_empty),
    .count    (rsp_count)
  );

  // Each entry starts its wait when it becomes head: on a push into an empty queue or on a pop.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wctr <= '0;
    end else if (pop || (accept && (rsp_count == '0))) begin
      wctr <= '0;
    end else if (!rsp_empty && (wctr != WAIT_MAX)) begin
      wctr <= wctr + 1'b1;
    end
  end

  assign dmem_recv  = !rsp_empty && (wctr == WAIT_MAX);
  assign pop        = dmem_recv && dmem_ack;
  assign dmem_error = dmem_recv && rsp_head.error;
  assign dmem_rdata = dmem_recv ? rsp_head.rdata : '0;

endmodule

// File: tb/tb_frv_dmem_responder.sv
// Bench for frv_dmem_responder: queue/array reference model plus directed literal checks.
module tb_frv_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0002_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAIT  = 0;
  localparam int unsigned RSP_D = 2;

  logic g_clk    = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        dmem_req = 0, dmem_wen = 0, dmem_ack = 0;
  logic [3:0]  dmem_strb = '0;
  logic [31:0] dmem_wdata = '0, dmem_addr = '0;
  logic        dmem_gnt, dmem_recv, dmem_error;
  logic [31:0] dmem_rdata;

  logic        w3_req = 0, w3_wen = 0, w3_ack = 0;
  logic [3:0]  w3_strb = '0;
  logic [31:0] w3_wdata = '0, w3_addr = '0;
  logic        w3_gnt, w3_recv, w3_error;
  logic [31:0] w3_rdata;

  frv_dmem_responder #(
    .DEPTH_WORDS (DEPTH), .BASE_ADDR (BASE), .WAIT_CYCLES (WAIT), .RSP_DEPTH (RSP_D)
  ) u_dut (
    .g_clk (g_clk), .g_resetn (g_resetn),
    .dmem_req (dmem_req), .dmem_wen (dmem_wen), .dmem_strb (dmem_strb),
    .dmem_wdata (dmem_wdata), .dmem_addr (dmem_addr), .dmem_gnt (dmem_gnt),
    .dmem_recv (dmem_recv), .dmem_ack (dmem_ack), .dmem_error (dmem_error),
    .dmem_rdata (dmem_rdata)
  );

  frv_dmem_responder #(
    .DEPTH_WORDS (DEPTH), .BASE_ADDR (BASE), .WAIT_CYCLES (3), .RSP_DEPTH (2)
  ) u_dut_w3 (
    .g_clk (g_clk), .g_resetn (g_resetn),
    .dmem_req (w3_req), .dmem_wen (w3_wen), .dmem_strb (w3_strb),
    .dmem_wdata (w3_wdata), .dmem_addr (w3_addr), .dmem_gnt (w3_gnt),
    .dmem_recv (w3_recv), .dmem_ack (w3_ack), .dmem_error (w3_error),
    .dmem_rdata (w3_rdata)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit done        = 0;
  logic [31:0] known [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Reference model: response queue, head start edge, and a plain array for memory.
  typedef struct { logic err; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] mmem [DEPTH];
  int          ecnt = 0;
  int          head_start = 0;

  function automatic bit m_recv();
    return (mq.size() > 0) && (ecnt >= head_start + int'(WAIT));
  endfunction

  initial begin : model
    int e;
    bit pop, acc, inr;
    ent_t n;
    int unsigned idx;
    longint unsigned a;
    forever begin
      @(posedge g_clk or negedge g_resetn);
      if (!g_resetn) begin
        mq.delete();
      end else begin
        e   = ecnt + 1;
        pop = m_recv() && dmem_ack;
        acc = dmem_req && (mq.size() != int'(RSP_D));
        if (pop) begin
          void'(mq.pop_front());
          if (mq.size() > 0) head_start = e;
        end
        if (acc) begin
          a   = dmem_addr;
          inr = (a >= longint'(BASE)) && (a < longint'(BASE) + 4 * DEPTH);
          n.err  = !inr;
          n.data = '0;
          if (inr) begin
            idx = int'((a - longint'(BASE)) >> 2);
            if (dmem_wen) begin
              for (int i = 0; i < 4; i++)
                if (dmem_strb[i]) mmem[idx][8*i +: 8] = dmem_wdata[8*i +: 8];
            end else begin
              n.data = mmem[idx];
            end
          end
          mq.push_back(n);
          if (mq.size() == 1) head_start = e;
        end
        ecnt = e;
      end
    end
  end

  initial begin : compare
    logic        eg, er, ee;
    logic [31:0] ed;
    forever begin
      @(negedge g_clk);
      if (!done) begin
        eg = g_resetn && dmem_req && (mq.size() != int'(RSP_D));
        er = g_resetn && m_recv();
        ee = er ? mq[0].err : 1'b0;
        ed = er ? mq[0].data : 32'h0;
        chk("m_gnt", dmem_gnt, eg);
        chk("m_recv", dmem_recv, er);
        chk("m_error", dmem_error, ee);
        chk("m_rdata", dmem_rdata, ed);
      end
    end
  end

  task automatic do_req(input logic w, input logic [3:0] s, input logic [31:0] wd,
                        input logic [31:0] a, output logic e, output logic [31:0] rd,
                        output int lat);
    bit ok;
    e = 1'b0; rd = '0; lat = 0;
    @(posedge g_clk); #1;
    dmem_req = 1; dmem_wen = w; dmem_strb = s; dmem_wdata = wd; dmem_addr = a; dmem_ack = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge g_clk);
      if (dmem_gnt) ok = 1;
      else begin @(posedge g_clk); #1; end
    end
    if (!ok) begin
      dmem_req = 0;
      timeout_fail("req_gnt");
      return;
    end
    @(posedge g_clk); #1;
    dmem_req = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge g_clk);
      lat++;
      if (dmem_recv) begin
        ok = 1; e = dmem_error; rd = dmem_rdata; dmem_ack = 1;
      end
    end
    if (!ok) timeout_fail("req_recv");
    else begin @(posedge g_clk); #1; dmem_ack = 0; end
  endtask

  task automatic w3_wait_recv(output int lat);
    bit ok;
    lat = 0; ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge g_clk);
      lat++;
      if (w3_recv) ok = 1;
    end
    if (!ok) timeout_fail("w3_recv");
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE - 4 * $urandom_range(1, 8);
      1:       return BASE + 32'h1000 + 4 * $urandom_range(0, 8);
      2:       return $urandom | 32'h8000_0000;
      3:       return BASE + 32'h0FFC + $urandom_range(0, 3);
      default: return BASE + 4 * $urandom_range(0, 31) + $urandom_range(0, 3);
    endcase
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic        e;
    logic [31:0] rd;
    int          lat;

    dmem_req = 1;
    #12;
    chk("rst_gnt", dmem_gnt, 1'b0);
    chk("rst_recv", dmem_recv, 1'b0);
    chk("rst_rdata", dmem_rdata, 32'h0);
    dmem_req = 0;
    @(posedge g_clk); #1;
    g_resetn = 1;

    for (int k = 0; k < 32; k++) begin
      known[k] = $urandom;
      do_req(1'b1, 4'hF, known[k], BASE + 4 * k, e, rd, lat);
    end

    do_req(1'b1, 4'hF, 32'hDEADBEEF, 32'h0002_0010, e, rd, lat);
    do_req(1'b0, 4'h0, 32'h0, 32'h0002_0010, e, rd, lat);
    chk("strb_rd1_data", rd, 32'hDEADBEEF);
    chk("strb_rd1_err", e, 1'b0);
    chk("strb_rd1_lat", lat, 1);
    do_req(1'b1, 4'b0010, 32'h0000_5500, 32'h0002_0010, e, rd, lat);
    chk("strb_wr_rsp", rd, 32'h0);
    do_req(1'b0, 4'h0, 32'h0, 32'h0002_0013, e, rd, lat);
    chk("strb_rd2_data", rd, 32'hDEAD55EF);
    chk("strb_rd2_err", e, 1'b0);
    known[4] = 32'hDEAD55EF;

    do_req(1'b0, 4'h0, 32'h0, 32'h0002_1000, e, rd, lat);
    chk("oor_rd_err", e, 1'b1);
    chk("oor_rd_data", rd, 32'h0);
    do_req(1'b1, 4'hF, 32'hA5A5_0FFC, 32'h0002_0FFC, e, rd, lat);
    known[1023] = 32'hA5A5_0FFC;
    do_req(1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0001_FFFC, e, rd, lat);
    chk("oor_wr_lo_err", e, 1'b1);
    do_req(1'b1, 4'hF, 32'h0000_0000, 32'h0002_1000, e, rd, lat);
    chk("oor_wr_hi_err", e, 1'b1);
    do_req(1'b0, 4'h0, 32'h0, 32'h0002_0FFC, e, rd, lat);
    chk("oor_top_word", rd, 32'hA5A5_0FFC);
    do_req(1'b0, 4'h0, 32'h0, BASE, e, rd, lat);
    chk("oor_word0", rd, known[0]);

    @(posedge g_clk); #1;
    dmem_ack = 0; dmem_req = 1; dmem_wen = 0; dmem_addr = BASE + 8;
    @(negedge g_clk); chk("bp_gnt1", dmem_gnt, 1'b1);
    @(posedge g_clk); #1; dmem_addr = BASE + 12;
    @(negedge g_clk); chk("bp_gnt2", dmem_gnt, 1'b1);
    @(posedge g_clk); #1; dmem_addr = BASE + 20;
    @(negedge g_clk); chk("bp_gnt3_full", dmem_gnt, 1'b0);
    @(posedge g_clk); #1; dmem_ack = 1;
    @(negedge g_clk);
    chk("bp_gnt_before_pop", dmem_gnt, 1'b0);
    chk("bp_rsp1", dmem_rdata, known[2]);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("bp_gnt_after_pop", dmem_gnt, 1'b1);
    chk("bp_rsp2", dmem_rdata, known[3]);
    @(posedge g_clk); #1; dmem_req = 0;
    @(negedge g_clk);
    chk("bp_rsp3_recv", dmem_recv, 1'b1);
    chk("bp_rsp3", dmem_rdata, known[5]);
    @(posedge g_clk); #1; dmem_ack = 0;

    @(posedge g_clk); #1;
    dmem_req = 1; dmem_wen = 0; dmem_addr = BASE;
    @(posedge g_clk); #1; dmem_addr = BASE + 4;
    @(posedge g_clk); #3;
    chk("mid_pre_recv", dmem_recv, 1'b1);
    g_resetn = 0;
    #1;
    chk("mid_rst_recv", dmem_recv, 1'b0);
    chk("mid_rst_gnt", dmem_gnt, 1'b0);
    chk("mid_rst_rdata", dmem_rdata, 32'h0);
    dmem_req = 0;
    @(posedge g_clk); @(posedge g_clk); #1;
    g_resetn = 1;
    do_req(1'b0, 4'h0, 32'h0, BASE + 8, e, rd, lat);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_data", rd, known[2]);

    @(posedge g_clk); #1;
    dmem_ack = 1; dmem_wen = 0;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin dmem_req = 1; dmem_addr = BASE + 4 * k; end
      else dmem_req = 0;
      @(negedge g_clk);
      if (k < 16) chk("stream_gnt", dmem_gnt, 1'b1);
      if (k >= 1) begin
        chk("stream_recv", dmem_recv, 1'b1);
        chk("stream_data", dmem_rdata, known[k-1]);
      end
      @(posedge g_clk); #1;
    end
    dmem_ack = 0;

    for (int c = 0; c < 400; c++) begin
      @(posedge g_clk); #1;
      dmem_req   = ($urandom_range(0, 3) != 0);
      dmem_wen   = $urandom_range(0, 1);
      dmem_strb  = 4'($urandom);
      dmem_wdata = $urandom;
      dmem_addr  = rand_addr();
      dmem_ack   = ($urandom_range(0, 3) != 0);
    end
    @(posedge g_clk); #1;
    dmem_req = 0; dmem_ack = 1;
    repeat (8) @(posedge g_clk);
    #1; dmem_ack = 0;

    @(posedge g_clk); #1;
    w3_req = 1; w3_wen = 1; w3_strb = 4'hF; w3_wdata = 32'h1234_5678; w3_addr = BASE;
    @(negedge g_clk); chk("w3_gnt_wr", w3_gnt, 1'b1);
    @(posedge g_clk); #1; w3_req = 0;
    w3_wait_recv(lat);
    chk("w3_wr_lat", lat, 4);
    chk("w3_wr_err", w3_error, 1'b0);
    w3_ack = 1;
    @(posedge g_clk); #1; w3_ack = 0;

    w3_req = 1; w3_wen = 0;
    @(negedge g_clk); chk("w3_gnt_rd", w3_gnt, 1'b1);
    @(posedge g_clk); #1; w3_req = 0;
    w3_wait_recv(lat);
    chk("w3_rd_lat", lat, 4);
    chk("w3_rd_data", w3_rdata, 32'h1234_5678);
    w3_ack = 1;
    @(posedge g_clk); #1; w3_ack = 0;

    w3_req = 1; w3_wen = 0; w3_addr = BASE;
    @(negedge g_clk); chk("w3_q_gnt1", w3_gnt, 1'b1);
    @(posedge g_clk); #1;
    w3_wen = 1; w3_strb = 4'h0; w3_addr = BASE + 8;
    @(negedge g_clk); chk("w3_q_gnt2", w3_gnt, 1'b1);
    @(posedge g_clk); #1; w3_req = 0;
    w3_wait_recv(lat);
    chk("w3_q_first_lat", lat, 3);
    chk("w3_q_first_data", w3_rdata, 32'h1234_5678);
    w3_ack = 1;
    @(posedge g_clk); #1; w3_ack = 0;
    w3_wait_recv(lat);
    chk("w3_q_second_lat", lat, 4);
    chk("w3_q_second_data", w3_rdata, 32'h0);
    w3_ack = 1;
    @(posedge g_clk); #1; w3_ack = 0;

    @(negedge g_clk);
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
